fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the write port of one 8-bit FIFO between NUM_REQ producers. Round-robin arbitration
//  with bounded bursts (up to MAX_BURST beats per grant). Drives FIFO wr_en/in and honours
//  FIFO full. Sits between producer blocks and the FIFO; the read side is not touched.
// PARAMETERS
//  NUM_REQ    4   number of requesters (2..8)
//  DATA_W     8   data width; must equal FIFO data width
//  MAX_BURST  4   max beats accepted from one owner per grant (1..15)
// PORTS
//  clk            in   1               rising-edge clock
//  reset          in   1               asynchronous, active-high reset
//  req            in   NUM_REQ         req[i]=1: requester i has a valid beat on its data slice
//  req_data       in   NUM_REQ*DATA_W  slice i = req_data[i*DATA_W +: DATA_W]
//  gnt            out  NUM_REQ         one-hot or zero; beat i transfers when req[i]&&gnt[i]
//  fifo_full      in   1               FIFO full flag
//  fifo_overflow  in   1               FIFO overflow flag
//  fifo_wr_en     out  1               FIFO write enable
//  fifo_in        out  DATA_W          FIFO write data
//  busy           out  1               1 while state==BURST
//  err_ovf        out  1               sticky; set when fifo_overflow is seen high
//  stat_cnt       out  NUM_REQ*16      per-requester beat counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, owner=NUM_REQ-1 (req 0 wins first), beat_cnt=0, err_ovf=0, stat_cnt=0;
//   gnt=0, fifo_wr_en=0, fifo_in=0, busy=0. Reset mid-burst aborts the burst with no write.
//  Registers: state {IDLE,BURST}, owner, beat_cnt. gnt, fifo_wr_en, fifo_in are combinational
//   from the registered owner/state and the live req/fifo_full.
//  gnt[i] = (state==BURST) && (owner==i) && !fifo_full.
//  fifo_wr_en = req[owner] && gnt[owner]; fifo_in = slice[owner] when fifo_wr_en, else 0.
//  RR pick: first i with req[i]=1, searching owner+1, owner+2, ... with wrap, owner last.
//  IDLE: if |req, then owner<=pick and state<=BURST; otherwise stay. Latency: req rise -> gnt is 1 cycle.
//  BURST: each transfer increments beat_cnt. Burst ends on the cycle where either:
//   - req[owner]==0 (no transfer that cycle); or
//   - a transfer makes beat_cnt reach MAX_BURST.
//  Burst end: beat_cnt<=0. If any req is set (the ending beat's own req counts), owner<=pick and
//   stay in BURST with no idle bubble. Otherwise go to IDLE.
//  Only the owner can re-win, and only when it is the sole requester.
//  fifo_full in BURST: gnt=0, no write, beat_cnt frozen, owner kept. The burst-end check for
//   req[owner]==0 still applies.
//  A dropped beat never occurs because writes are gated by full. fifo_overflow==1 sets err_ovf,
//   which clears only on reset.
//  Requesters hold req and data stable until granted. A change of data without gnt is ignored.
// CONFIGURATION
//  Macro FIFO_WR_ARB_STATS_EN:
//   - defined: stat_cnt slice i increments on every req[i]&&gnt[i] and saturates at 16'hFFFF.
//   - undefined: no counter logic is built and stat_cnt is tied to 0. The port list is unchanged.
// STRUCTURE
//  Package fifo_wr_arb_pkg holds:
//   - typedef enum logic {IDLE, BURST} arb_state_t
//   - localparam STAT_W=16
//   - function burst_cnt_w(MAX_BURST) giving $clog2(MAX_BURST+1)
//  Sub-module fifo_wr_arb_rr_pick: combinational round-robin picker
//   (req, owner -> pick, any). Everything else lives in the top module.
// TESTING
//  T1 reset: reset=1 during req=4'b1111 -> gnt=0, fifo_wr_en=0, busy=0, err_ovf=0, stat_cnt=0.
//  T2 single requester: req=4'b0010 held, data=8'h10..8'h15, FIFO empty.
//   -> gnt=4'b0010 from cycle 2; 4 writes; burst end; req 1 re-picked with no bubble.
//   -> FIFO holds 8'h10..8'h15 in order.
//  T3 fairness: req=4'b1111 held, MAX_BURST=4.
//   -> owner sequence 0,1,2,3,0, with exactly 4 beats each; fifo_wr_en is high every cycle once busy.
//  T4 backpressure: fifo_full=1 for 3 cycles mid-burst after 2 beats.
//   -> gnt=0 and fifo_wr_en=0 for those cycles; 2 more beats after release, then handover.
//  T5 early drop: owner 2 drops req after 1 beat, req[0] pending.
//   -> owner becomes 0 next cycle; a burst with only req 2 active (req=4'b0100) ends and goes to IDLE.
//  T6 overflow/stats: force fifo_overflow=1 for one cycle -> err_ovf=1 until reset.
//   -> with STATS_EN, after T3 for 8 grants, stat_cnt slice 0 = 16'd8.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_t;

  localparam int STAT_W = 16;

  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first requester after owner (with wrap), owner itself last.
module fifo_wr_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   owner,
  output logic [OWN_W-1:0]   pick,
  output logic               any
);

  int idx;

  // Walk from the farthest candidate to the nearest so the nearest one overwrites.
  always_comb begin
    pick = owner;
    any  = 1'b0;
    idx  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(owner) + k) % NUM_REQ;
      if (req[idx]) begin
        pick = OWN_W'(idx);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded sharing of one FIFO write port among NUM_REQ producers.
// Optional per-requester beat counters are built when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      fifo_full,
  input  logic                      fifo_overflow,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_in,
  output logic                      busy,
  output logic                      err_ovf,
  output logic [NUM_REQ*STAT_W-1:0] stat_cnt
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = burst_cnt_w(MAX_BURST);
  localparam logic [OWN_W-1:0] OWN_RST  = OWN_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t        state;
  logic [OWN_W-1:0]  owner;
  logic [OWN_W-1:0]  pick;
  logic [CNT_W-1:0]  beat_cnt;
  logic              any;
  logic              xfer;
  logic              burst_end;
  logic [DATA_W-1:0] owner_data;

  fifo_wr_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_pick (
    .req   (req),
    .owner (owner),
    .pick  (pick),
    .any   (any)
  );

  always_comb begin
    gnt = '0;
    if ((state == BURST) && !fifo_full) begin
      gnt[owner] = 1'b1;
    end
  end

  assign owner_data = req_data[int'(owner)*DATA_W +: DATA_W];
  assign xfer       = req[owner] && gnt[owner];
  assign fifo_wr_en = xfer;
  assign fifo_in    = xfer ? owner_data : '0;
  assign busy       = (state == BURST);

  // A stalled owner (full) keeps its slot; only dropping req or the last beat ends the burst.
  assign burst_end = !req[owner] || (xfer && (beat_cnt == CNT_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= OWN_RST;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (any) begin
            owner <= pick;
            state <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            beat_cnt <= '0;
            if (any) begin
              owner <= pick;
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf <= 1'b0;
    end else if (fifo_overflow) begin
      err_ovf <= 1'b1;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (req[i] && gnt[i] && (cnt != {STAT_W{1'b1}})) begin
        cnt <= cnt + STAT_W'(1);
      end
    end
    assign stat_cnt[i*STAT_W +: STAT_W] = cnt;
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a cycle-level burst model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            fifo_full;
  logic            fifo_overflow;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_in;
  logic            busy;
  logic            err_ovf;
  logic [N*16-1:0] stat_cnt;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .fifo_full     (fifo_full),
    .fifo_overflow (fifo_overflow),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_in       (fifo_in),
    .busy          (busy),
    .err_ovf       (err_ovf),
    .stat_cnt      (stat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [N-1:0]    gnt;
    logic            busy;
    logic            wr;
    logic [DW-1:0]   din;
    logic            err;
    logic [N*16-1:0] stat;
  } cyc_t;

  wr_t  wr_q[$];
  cyc_t cyc_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: whether a burst is running, who owns it, beats taken so far.
  bit  m_busy;
  int  m_owner;
  int  m_beats;
  bit  m_err;
  int  m_stat[N];

  // Producers: hold[i] means requester i is presenting pdata[i] and waits for a grant.
  bit            hold[N];
  logic [DW-1:0] pdata[N];
  int            mode;   // 0 random, 1 everyone always requests, 2 only requester 1

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return from;
  endfunction

  function automatic bit want_more(input int i);
    if (mode == 1) return 1'b1;
    if (mode == 2) return (i == 1);
    return ($urandom % 4) != 0;
  endfunction

  function automatic bit want_start(input int i);
    if (mode == 1) return 1'b1;
    if (mode == 2) return (i == 1);
    return ($urandom % 3) == 0;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = N - 1;
    m_beats = 0;
    m_err   = 1'b0;
    for (int i = 0; i < N; i++) m_stat[i] = 0;
  endtask

  task automatic step(input bit rst_in, input bit full_in, input bit ovf_in);
    cyc_t         c;
    wr_t          w;
    logic [N-1:0] r;
    bit           wr;
    int           o;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      r[i] = hold[i];
      req_data[i*DW +: DW] = pdata[i];
    end
    req           = r;
    reset         = rst_in;
    fifo_full     = full_in;
    fifo_overflow = ovf_in;

    if (rst_in) begin
      c.gnt = '0; c.busy = 1'b0; c.wr = 1'b0; c.din = '0; c.err = 1'b0; c.stat = '0;
      cyc_q.push_back(c);
      model_reset();
      return;
    end

    o  = m_owner;
    wr = m_busy && !full_in && r[o];
    c.gnt  = (m_busy && !full_in) ? (N'(1) << o) : '0;
    c.busy = m_busy;
    c.wr   = wr;
    c.din  = wr ? pdata[o] : '0;
    c.err  = m_err;
    c.stat = '0;
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) c.stat[i*16 +: 16] = 16'(m_stat[i]);
`endif
    cyc_q.push_back(c);
    if (wr) begin
      w.idx  = o;
      w.data = pdata[o];
      wr_q.push_back(w);
    end

    if (!m_busy) begin
      if (r != '0) begin
        m_busy  = 1'b1;
        m_owner = rr_next(r, o);
      end
    end else begin
      if (wr) m_beats++;
      if (!r[o] || (wr && m_beats == MB)) begin
        m_beats = 0;
        if (r != '0) m_owner = rr_next(r, o);
        else m_busy = 1'b0;
      end
    end
    if (ovf_in) m_err = 1'b1;
    if (wr && m_stat[o] < 65535) m_stat[o]++;

    for (int i = 0; i < N; i++) begin
      if (wr && i == o) begin
        hold[i]  = want_more(i);
        pdata[i] = DW'($urandom_range(0, 255));
      end else if (!hold[i]) begin
        hold[i]  = want_start(i);
        pdata[i] = DW'($urandom_range(0, 255));
      end
    end
  endtask

  cyc_t mc;
  wr_t  mw;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() > 0) begin
        mc = cyc_q.pop_front();
        chk("gnt", 64'(gnt), 64'(mc.gnt));
        chk("busy", 64'(busy), 64'(mc.busy));
        chk("fifo_wr_en", 64'(fifo_wr_en), 64'(mc.wr));
        chk("fifo_in", 64'(fifo_in), 64'(mc.din));
        chk("err_ovf", 64'(err_ovf), 64'(mc.err));
        chk("stat_cnt", 64'(stat_cnt), 64'(mc.stat));
        if (fifo_wr_en === 1'b1) begin
          if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write_order: got write of %h, expected no pending beat", fifo_in);
          end else begin
            mw = wr_q.pop_front();
            chk("write_data", 64'(fifo_in), 64'(mw.data));
            chk("write_src", 64'(gnt), 64'(N'(1) << mw.idx));
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; fifo_overflow = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      hold[i]  = 1'b1;
      pdata[i] = DW'($urandom_range(0, 255));
    end

    // Reset with every requester asserting.
    mode = 1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Lone requester 1: back-to-back bursts with no idle bubble.
    mode = 2;
    for (int i = 0; i < N; i++) hold[i] = (i == 1);
    step(1'b1, 1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b0, 1'b0);

    // All requesting: strict rotation, then periodic full stalls mid-burst.
    mode = 1;
    for (int i = 0; i < N; i++) hold[i] = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 44; c++) step(1'b0, ((c % 11) >= 7) && ((c % 11) < 10), 1'b0);

    // Single overflow pulse must stick.
    step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0);

    // Random traffic with stalls, overflows and occasional mid-burst resets.
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 400) == 0, ($urandom % 5) == 0, ($urandom % 200) == 0);
    end

    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #4;
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("cyc_q_drained", 64'(cyc_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
